// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Receives a byte stream (16-bit little-endian word count, then 4 bytes per
// word, LSB first). It packs each group of 4 bytes into a 32-bit word and
// writes it to instruction memory. It flags word counts that exceed the memory
// capacity, and it flags words whose opcode the control unit cannot decode.
// The CPU is held in reset for the whole session.

module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_len_err,
   output logic              o_op_err,
   output logic [ADDR_W-1:0] o_bad_addr
);

   // Memory capacity in words; a declared length equal to this is still legal.
   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t            r_state;
   logic [15:0]       r_len;
   logic [ADDR_W:0]   r_idx;       // one extra bit so N = 2^ADDR_W is reachable
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_shreg;     // bytes 0..2 of the word being assembled
   logic              r_rx_ready;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_hold;
   logic              r_done;
   logic              r_len_err;
   logic              r_op_err;
   logic [ADDR_W-1:0] r_bad_addr;

   logic [15:0]       w_len_full;
   logic              w_len_too_big;
   logic              w_last_word;
   logic              w_op_ok;

   assign w_len_full    = {i_rx_data, r_len[7:0]};
   assign w_len_too_big = {1'b0, w_len_full} > CAPACITY;
   assign w_last_word   = (16'(r_idx) == (r_len - 16'd1));

   // Decode the word currently on the write port against the supported opcodes.
   always_comb begin
      // NOTE: a default before the case gives every path a value, so no latch is inferred.
      w_op_ok = 1'b0;
      case (r_imem_wdata[6:0])
         7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
         7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111: w_op_ok = 1'b1;
         default:                                        w_op_ok = 1'b0;
      endcase
   end

   // Session FSM; every output is a register updated together with the state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_idx        <= '0;
         r_byte_cnt   <= '0;
         r_shreg      <= '0;
         r_rx_ready   <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_hold       <= 1'b0;
         r_done       <= 1'b0;
         r_len_err    <= 1'b0;
         r_op_err     <= 1'b0;
         r_bad_addr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_LEN0;
                  r_rx_ready <= 1'b1;
                  r_hold     <= 1'b1;
                  r_len_err  <= 1'b0;
                  r_op_err   <= 1'b0;
                  r_bad_addr <= '0;
                  r_len      <= '0;
                  r_idx      <= '0;
                  r_byte_cnt <= '0;
               end
            end

            S_LEN0: begin
               if (i_rx_valid) begin
                  r_len[7:0] <= i_rx_data;
                  r_state    <= S_LEN1;
               end
            end

            S_LEN1: begin
               if (i_rx_valid) begin
                  r_len <= w_len_full;
                  if (w_len_too_big) begin
                     r_state    <= S_ERR;
                     r_rx_ready <= 1'b0;
                     r_len_err  <= 1'b1;
                  end else if (w_len_full == 16'd0) begin
                     r_state    <= S_DONE;
                     r_rx_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end else begin
                     r_state    <= S_DATA;
                     r_idx      <= '0;
                     r_byte_cnt <= '0;
                  end
               end
            end

            S_DATA: begin
               if (i_rx_valid) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  case (r_byte_cnt)
                     2'd0: r_shreg[7:0]   <= i_rx_data;
                     2'd1: r_shreg[15:8]  <= i_rx_data;
                     2'd2: r_shreg[23:16] <= i_rx_data;
                     default: begin
                        r_state      <= S_WRITE;
                        r_rx_ready   <= 1'b0;
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_idx[ADDR_W-1:0];
                        r_imem_wdata <= {i_rx_data, r_shreg};
                     end
                  endcase
               end
            end

            S_WRITE: begin
               r_imem_we <= 1'b0;
               // Only the first offending word is recorded; the load carries on.
               if (!w_op_ok && !r_op_err) begin
                  r_op_err   <= 1'b1;
                  r_bad_addr <= r_imem_addr;
               end
               if (w_last_word) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_DATA;
                  r_idx      <= r_idx + 1'b1;
                  r_byte_cnt <= '0;
                  r_rx_ready <= 1'b1;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_hold  <= 1'b0;
            end

            S_ERR: begin
               r_state <= S_IDLE;
               r_hold  <= 1'b0;
            end

            default: begin
               r_state    <= S_IDLE;
               r_rx_ready <= 1'b0;
               r_imem_we  <= 1'b0;
               r_hold     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_imem_we    = r_imem_we;
   assign o_imem_addr  = r_imem_addr;
   assign o_imem_wdata = r_imem_wdata;
   assign o_cpu_hold   = r_hold;
   assign o_busy       = r_hold;
   assign o_done       = r_done;
   assign o_len_err    = r_len_err;
   assign o_op_err     = r_op_err;
   assign o_bad_addr   = r_bad_addr;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W = 8).
// A negedge monitor records every memory write and every done pulse. Directed
// loads, including a table of single-word opcode vectors, are then checked
// against values computed by hand.

module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              len_err;
   logic              op_err;
   logic [ADDR_W-1:0] bad_addr;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_rx_data   (rx_data),
      .i_rx_valid  (rx_valid),
      .o_rx_ready  (rx_ready),
      .o_imem_we   (imem_we),
      .o_imem_addr (imem_addr),
      .o_imem_wdata(imem_wdata),
      .o_cpu_hold  (cpu_hold),
      .o_busy      (busy),
      .o_done      (done),
      .o_len_err   (len_err),
      .o_op_err    (op_err),
      .o_bad_addr  (bad_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Scoreboard filled by the monitor.
   logic [31:0] cap_mem [0:255];
   int          wr_cnt;
   int          done_cnt;
   int          overlap_cnt;
   int          hold_busy_cnt;

   logic [31:0] stim [$];

   typedef struct {
      logic [31:0] word;
      logic        exp_op_err;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Record writes and done pulses away from the active edge.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         cap_mem[imem_addr] = imem_wdata;
         wr_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (imem_we === 1'b1 && done === 1'b1) overlap_cnt++;
      if (cpu_hold !== busy) hold_busy_cnt++;
   end

   task automatic clear_sb();
      for (int i = 0; i < 256; i++) cap_mem[i] = 32'hDEAD_BEEF;
      wr_cnt   = 0;
      done_cnt = 0;
   endtask

   // Called and returns at 1 time unit after a rising edge.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Presents one byte after `gap` idle cycles and waits (bounded) for its transfer.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (rx_ready === 1'b1) break;
         t++;
         if (t > 50) begin
            failed++;
            tests++;
            $display("FAIL rx_ready_timeout: byte 0x%0h never accepted", b);
            break;
         end
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Runs one session from the start pulse. stop_after < 0 sends the whole stream;
   // otherwise only that many bytes are sent. start_at injects a start pulse before that byte.
   task automatic load(input logic [15:0] n, input int maxgap, input int start_at,
                       input int stop_after, input bit tail);
      int          total;
      int          gap;
      logic [31:0] w;
      logic [7:0]  b;
      pulse_start();
      check("start_latency", {61'd0, cpu_hold, busy, rx_ready}, 64'd7);
      total = 2 + 4 * int'(n);
      if (stop_after >= 0) total = stop_after;
      for (int k = 0; k < total; k++) begin
         if (k == 0)      b = n[7:0];
         else if (k == 1) b = n[15:8];
         else begin
            w = stim[(k - 2) / 4];
            b = w[8 * ((k - 2) % 4) +: 8];
         end
         gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
         if (k == start_at) pulse_start();
         send_byte(b, gap);
      end
      if (tail && n != 16'd0) begin
         check("tail_write_cycle", {62'd0, imem_we, done}, 64'd2);
         @(posedge clk); #1;
         check("tail_done_cycle", {61'd0, done, cpu_hold, imem_we}, 64'd6);
         @(posedge clk); #1;
         check("tail_idle_cycle", {62'd0, done, cpu_hold}, 64'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h0000_0033, 1'b0};
      vecs[1]  = '{32'h0000_2003, 1'b0};
      vecs[2]  = '{32'h0010_0013, 1'b0};
      vecs[3]  = '{32'h0000_8067, 1'b0};
      vecs[4]  = '{32'h0011_2023, 1'b0};
      vecs[5]  = '{32'h0000_0063, 1'b0};
      vecs[6]  = '{32'h1234_50B7, 1'b0};
      vecs[7]  = '{32'h0000_006F, 1'b0};
      vecs[8]  = '{32'h0000_000F, 1'b1};
      vecs[9]  = '{32'h0000_0073, 1'b1};
      vecs[10] = '{32'h0000_0017, 1'b1};
      vecs[11] = '{32'h0000_0032, 1'b1};

      overlap_cnt   = 0;
      hold_busy_cnt = 0;
      reset    = 1'b1;
      start    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      clear_sb();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      check("reset_outputs",
            {9'd0, rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done,
             len_err, op_err, bad_addr}, 64'd0);

      // Two-word load, continuous valid.
      clear_sb();
      stim = {32'h0010_0093, 32'h0020_8133};
      load(16'd2, 0, -1, -1, 1'b1);
      check("basic_wr_cnt", 64'(wr_cnt), 64'd2);
      check("basic_word0", {32'd0, cap_mem[0]}, 64'h0010_0093);
      check("basic_word1", {32'd0, cap_mem[1]}, 64'h0020_8133);
      check("basic_done_cnt", 64'(done_cnt), 64'd1);
      check("basic_flags", {62'd0, op_err, len_err}, 64'd0);

      // Opcode table, one word per session.
      for (int v = 0; v < 12; v++) begin
         clear_sb();
         stim = {vecs[v].word};
         load(16'd1, 0, -1, -1, 1'b1);
         check($sformatf("vec%0d_wdata", v), {32'd0, cap_mem[0]}, {32'd0, vecs[v].word});
         check($sformatf("vec%0d_op_err", v), {63'd0, op_err}, {63'd0, vecs[v].exp_op_err});
         check($sformatf("vec%0d_bad_addr", v), {56'd0, bad_addr}, 64'd0);
      end

      // Full capacity: 256 words.
      clear_sb();
      stim = {};
      for (int i = 0; i < 256; i++) stim.push_back(32'h0000_0013 | (32'(i) << 20));
      load(16'd256, 0, -1, -1, 1'b1);
      check("cap_wr_cnt", 64'(wr_cnt), 64'd256);
      check("cap_word0", {32'd0, cap_mem[0]}, 64'h0000_0013);
      check("cap_word255", {32'd0, cap_mem[255]}, 64'h0FF0_0013);
      check("cap_done_cnt", 64'(done_cnt), 64'd1);
      check("cap_len_err", {63'd0, len_err}, 64'd0);

      // 257 words: length error.
      clear_sb();
      load(16'd257, 0, -1, 2, 1'b0);
      check("len_err_rise", {61'd0, len_err, cpu_hold, rx_ready}, 64'd6);
      @(posedge clk); #1;
      check("len_err_idle", {62'd0, len_err, cpu_hold}, 64'd2);
      repeat (5) @(posedge clk);
      #1;
      check("len_err_no_writes", 64'(wr_cnt), 64'd0);
      check("len_err_no_done", 64'(done_cnt), 64'd0);

      // Zero-length session.
      clear_sb();
      load(16'd0, 0, -1, -1, 1'b0);
      check("zero_done", {62'd0, done, imem_we}, 64'd2);
      @(posedge clk); #1;
      check("zero_idle", {62'd0, done, cpu_hold}, 64'd0);
      check("zero_no_writes", 64'(wr_cnt), 64'd0);

      // First bad opcode recorded, later bad word ignored.
      clear_sb();
      stim = {32'h0010_0093, 32'h0000_007F, 32'h0000_0000};
      load(16'd3, 0, -1, -1, 1'b1);
      check("op_wr_cnt", 64'(wr_cnt), 64'd3);
      check("op_word1", {32'd0, cap_mem[1]}, 64'h0000_007F);
      check("op_word2", {32'd0, cap_mem[2]}, 64'h0000_0000);
      check("op_err_set", {63'd0, op_err}, 64'd1);
      check("op_bad_addr", {56'd0, bad_addr}, 64'd1);

      // Random gaps with a stray start pulse in the middle of the data.
      clear_sb();
      stim = {32'h0010_0093, 32'h0020_8133};
      load(16'd2, 5, 5, -1, 1'b1);
      check("gap_wr_cnt", 64'(wr_cnt), 64'd2);
      check("gap_word0", {32'd0, cap_mem[0]}, 64'h0010_0093);
      check("gap_word1", {32'd0, cap_mem[1]}, 64'h0020_8133);
      check("gap_done_cnt", 64'(done_cnt), 64'd1);

      // Reset after 6 data bytes; word 0 carries a bad opcode so op_err is set.
      clear_sb();
      stim = {32'h0000_007F, 32'h0020_8133};
      load(16'd2, 0, -1, 8, 1'b0);
      check("mid_op_err_before", {63'd0, op_err}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("mid_reset_outputs",
            {9'd0, rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done,
             len_err, op_err, bad_addr}, 64'd0);
      check("mid_wr_cnt", 64'(wr_cnt), 64'd1);
      clear_sb();
      stim = {32'h0010_0093, 32'h0020_8133};
      load(16'd2, 0, -1, -1, 1'b1);
      check("after_reset_word0", {32'd0, cap_mem[0]}, 64'h0010_0093);
      check("after_reset_word1", {32'd0, cap_mem[1]}, 64'h0020_8133);
      check("after_reset_done", 64'(done_cnt), 64'd1);

      check("done_we_overlap", 64'(overlap_cnt), 64'd0);
      check("hold_busy_equal", 64'(hold_busy_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the fetch stage and decoded by the control unit. It accepts a byte stream on a valid/ready interface, packs bytes little-endian into 32-bit instruction words, and writes one word per imem write strobe. It also checks each word's opcode against the set the control unit supports. While a load is in progress, it holds the CPU in reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load session; ignored unless state is IDLE
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; a transfer occurs on rx_valid && rx_ready at a rising edge
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address, valid while imem_we=1
- imem_wdata  out  32  instruction word, valid while imem_we=1
- cpu_hold  out  1  high whenever state is not IDLE; drives the core's reset
- busy  out  1  same as cpu_hold
- done  out  1  one-cycle pulse at successful session end
- len_err  out  1  sticky; set when the declared length exceeds capacity; cleared by start or reset
- op_err  out  1  sticky; set when any written word has an unsupported opcode; cleared by start or reset
- bad_addr  out  ADDR_W  address of the first word with an unsupported opcode; meaningful only while op_err=1

## Operation
- Stream format:
  - Byte 0 is N[7:0] and byte 1 is N[15:8], where N is the word count.
  - These are followed by 4·N instruction bytes, each word sent LSB first.
- States:
  - IDLE → LEN0 on start.
  - LEN0 → LEN1 on a byte transfer, which latches N[7:0].
  - LEN1 → next state on a byte transfer, which latches N[15:8]. The next state is:
    - ERR if N > 2^ADDR_W;
    - DONE if N = 0;
    - DATA otherwise.
  - DATA: a 2-bit byte counter fills a 32-bit shift register, with byte k going to bits [8k+7:8k]. The 4th transfer → WRITE.
  - WRITE: imem_we=1, imem_addr = word index, imem_wdata = packed word. Then:
    - → DONE if index = N−1;
    - otherwise → DATA with index+1 and byte counter cleared.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: len_err=1 → IDLE next cycle. No memory writes occur and done is not asserted.
- rx_ready is 1 in LEN0, LEN1 and DATA only; it is 0 in IDLE, WRITE, DONE and ERR.
- Supported opcodes, checked on wdata[6:0] in WRITE: 0110011, 0000011, 0010011, 1100111, 0100011, 1100011, 0110111, 1101111.
- On the first unsupported opcode:
  - op_err is set and bad_addr captures the address;
  - later bad words do not update bad_addr;
  - the word is still written and the load continues.
- Word index is ADDR_W+1 bits wide, which permits N = 2^ADDR_W exactly; imem_addr is its low ADDR_W bits.
- Reset values: state IDLE; rx_ready, imem_we, cpu_hold, busy, done, len_err and op_err all 0; imem_addr, imem_wdata, bad_addr, N and counters all 0.
- Reset mid-session: return to IDLE immediately and clear all flags. Memory contents already written are left as is. Any partial word is discarded.
- start while not IDLE has no effect.
- Stalls: rx_valid low for any number of cycles holds the state. There is no timeout.

## Timing
- All outputs are registered.
- Latency from start to rx_ready: start sampled at edge t gives LEN0 and rx_ready=1 in cycle t+1.
- A 4th-byte transfer at edge t gives imem_we=1 in cycle t+1 (the WRITE state).
- The next byte can transfer no earlier than edge t+2. Peak rate is 4 bytes per 5 cycles.
- Last word: WRITE in cycle t+1, done=1 and cpu_hold=1 in cycle t+2, IDLE with cpu_hold=0 in cycle t+3.
- N=0: byte-1 transfer at edge t gives done in cycle t+1.
- Length error: byte-1 transfer at edge t gives ERR in cycle t+1 with len_err rising. In cycle t+2 the state is IDLE and len_err stays 1.
- done and imem_we are never high in the same cycle.

## Test plan
- ADDR_W=8, start, stream 02 00 | 93 00 10 00 | 33 81 20 00 with rx_valid continuously high:
  - imem_we at addr 0 with 0x00100093, then addr 1 with 0x00208133;
  - done exactly once; op_err=0; cpu_hold high from the cycle after start through the done cycle.
- Length 00 01 (256) with ADDR_W=8: 256 writes, the last at addr 0xFF, done asserted, len_err=0. Length 01 01 (257): len_err=1, zero writes, no done.
- Length 00 00: done 1 cycle after the 2nd byte, no imem_we.
- 3 words where word 1 is 0x0000007F and word 2 is 0x00000000:
  - all 3 written;
  - op_err=1 and bad_addr=1, unchanged by word 2.
- Random rx_valid gaps of 0–5 cycles plus a start pulse mid-session: the written data is identical to the gap-free run and the extra start is ignored.
- reset asserted after 6 data bytes: next cycle all outputs 0, state IDLE. A subsequent full load then completes correctly.
